// File: rtl/txarb_pkg.sv
// Shared types and default timing constants for the transmit frame arbiter.
package txarb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    PASS     = 2'd2,
    GAP      = 2'd3
  } txarb_state_t;

  localparam int TXARB_IFG_DEFAULT       = 12;
  localparam int TXARB_SOF_TO_DEFAULT    = 64;
  localparam int TXARB_MAX_FRAME_DEFAULT = 1518;

endpackage

// File: rtl/txarb_rr_pick.sv
// Grant selector: source 0 has fixed priority, sources 1..N-1 are searched
// upward from rr_ptr with wrap-around.
module txarb_rr_pick
  import txarb_pkg::*;
#(
  parameter int N_SRC = 2,
  localparam int IW = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] ReqIn,
  input  logic [IW-1:0]    rr_ptr,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_idx
);

  always_comb begin : pick
    int c;
    c           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (ReqIn[0]) begin
      grant_valid = 1'b1;
    end else begin
      // Walk the search order backwards so the candidate nearest rr_ptr wins.
      for (int k = N_SRC - 2; k >= 0; k--) begin
        c = ((int'(rr_ptr) + N_SRC - 2 + k) % (N_SRC - 1)) + 1;
        if (ReqIn[c]) begin
          grant_valid = 1'b1;
          grant_idx   = IW'(c);
        end
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Shares the L2 transmit path between N_SRC byte-stream sources with an IFG.
// Optional runaway-frame watchdog: define TXARB_WATCHDOG_EN.
module tx_frame_arbiter
  import txarb_pkg::*;
#(
  parameter int N_SRC           = 2,
  parameter int IFG_CYCLES      = TXARB_IFG_DEFAULT,
  parameter int SOF_TIMEOUT     = TXARB_SOF_TO_DEFAULT,
  parameter int MAX_FRAME_BYTES = TXARB_MAX_FRAME_DEFAULT,
  localparam int IW = $clog2(N_SRC)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               LinkUp,
  input  logic [N_SRC-1:0]   ReqIn,
  input  logic [N_SRC-1:0]   ValIn,
  input  logic [N_SRC-1:0]   SoFIn,
  input  logic [N_SRC-1:0]   EoFIn,
  input  logic [8*N_SRC-1:0] DataIn,
  output logic [N_SRC-1:0]   ReqConfirm,
  output logic               ValOut,
  output logic               SoFOut,
  output logic               EoFOut,
  output logic               ErrOut,
  output logic [7:0]         DataOut,
  output logic               Busy,
  output logic [IW-1:0]      Owner
);

  localparam int CNT_MAX = (IFG_CYCLES > SOF_TIMEOUT) ? IFG_CYCLES : SOF_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  if (N_SRC < 2 || N_SRC > 8 || IFG_CYCLES < 1 || SOF_TIMEOUT < 1 ||
      MAX_FRAME_BYTES < 1 || MAX_FRAME_BYTES > 2047) begin : g_bad_params
    $error("tx_frame_arbiter: parameter out of supported range");
  end

  txarb_state_t       state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [IW-1:0]      owner_reg, owner_next;
  logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [N_SRC-1:0]   confirm_reg, confirm_next;
  logic               val_reg, val_next, sof_reg, sof_next;
  logic               eof_reg, eof_next, err_reg, err_next;
  logic [7:0]         data_reg, data_next;
  logic               grant_valid;
  logic [IW-1:0]      grant_idx;
  logic [7:0]         src_data [N_SRC];
  logic               sel_val, sel_sof, sel_eof;
  logic [7:0]         sel_data;
  logic               wdog_trip, abort;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src_bytes
    assign src_data[gi] = DataIn[8*gi +: 8];
  end

  assign sel_val  = ValIn[owner_reg];
  assign sel_sof  = SoFIn[owner_reg];
  assign sel_eof  = EoFIn[owner_reg];
  assign sel_data = src_data[owner_reg];

`ifdef TXARB_WATCHDOG_EN
  logic [10:0] byte_cnt_reg, byte_cnt_next;
  assign wdog_trip = (byte_cnt_reg >= 11'(MAX_FRAME_BYTES));
`else
  assign wdog_trip = 1'b0;
`endif

  // Abort replaces whatever the owner presents this cycle with an error EoF.
  assign abort = (state_reg == PASS) && (!LinkUp || wdog_trip);

  txarb_rr_pick #(.N_SRC(N_SRC)) u_pick (
    .ReqIn      (ReqIn),
    .rr_ptr     (rr_ptr_reg),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      owner_reg   <= '0;
      rr_ptr_reg  <= IW'(1);
      confirm_reg <= '0;
      val_reg     <= 1'b0;
      sof_reg     <= 1'b0;
      eof_reg     <= 1'b0;
      err_reg     <= 1'b0;
      data_reg    <= '0;
`ifdef TXARB_WATCHDOG_EN
      byte_cnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      owner_reg   <= owner_next;
      rr_ptr_reg  <= rr_ptr_next;
      confirm_reg <= confirm_next;
      val_reg     <= val_next;
      sof_reg     <= sof_next;
      eof_reg     <= eof_next;
      err_reg     <= err_next;
      data_reg    <= data_next;
`ifdef TXARB_WATCHDOG_EN
      byte_cnt_reg <= byte_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    owner_next   = owner_reg;
    rr_ptr_next  = rr_ptr_reg;
    confirm_next = '0;
`ifdef TXARB_WATCHDOG_EN
    byte_cnt_next = byte_cnt_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (LinkUp && grant_valid) begin
          confirm_next[grant_idx] = 1'b1;
          owner_next              = grant_idx;
          state_next              = WAIT_SOF;
          if (grant_idx != '0)
            rr_ptr_next = (grant_idx == IW'(N_SRC - 1)) ? IW'(1) : grant_idx + IW'(1);
        end
      end
      WAIT_SOF: begin
        if (!LinkUp) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (sel_val && sel_sof) begin
          state_next = sel_eof ? GAP : PASS;
          cnt_next   = '0;
`ifdef TXARB_WATCHDOG_EN
          byte_cnt_next = 11'd1;
`endif
        end else if (cnt_reg == CW'(SOF_TIMEOUT - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PASS: begin
        if (abort || (sel_val && sel_eof)) begin
          state_next = GAP;
          cnt_next   = '0;
        end
`ifdef TXARB_WATCHDOG_EN
        else if (sel_val) begin
          byte_cnt_next = byte_cnt_reg + 11'd1;
        end
`endif
      end
      GAP: begin
        if (cnt_reg == CW'(IFG_CYCLES - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    val_next  = 1'b0;
    sof_next  = 1'b0;
    eof_next  = 1'b0;
    err_next  = 1'b0;
    data_next = '0;
    if (state_reg == WAIT_SOF && LinkUp && sel_val && sel_sof) begin
      val_next  = 1'b1;
      sof_next  = 1'b1;
      eof_next  = sel_eof;
      data_next = sel_data;
    end else if (abort) begin
      eof_next = 1'b1;
      err_next = 1'b1;
    end else if (state_reg == PASS) begin
      val_next  = sel_val;
      sof_next  = sel_sof;
      eof_next  = sel_eof;
      data_next = sel_data;
    end
  end

  assign ReqConfirm = confirm_reg;
  assign ValOut     = val_reg;
  assign SoFOut     = sof_reg;
  assign EoFOut     = eof_reg;
  assign ErrOut     = err_reg;
  assign DataOut    = data_reg;
  assign Busy       = (state_reg != IDLE);
  assign Owner      = owner_reg;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter with four sources and default timing.
module tb_tx_frame_arbiter;

  localparam int N   = 4;
  localparam int IFG = 12;
  localparam int STO = 64;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         LinkUp;
  logic [N-1:0] ReqIn, ValIn, SoFIn, EoFIn;
  logic [8*N-1:0] DataIn;
  logic [N-1:0] ReqConfirm;
  logic         ValOut, SoFOut, EoFOut, ErrOut, Busy;
  logic [7:0]   DataOut;
  logic [1:0]   Owner;

  int total = 0;
  int bad   = 0;

  tx_frame_arbiter #(.N_SRC(N)) dut (
    .Clk(Clk), .Rst(Rst), .LinkUp(LinkUp), .ReqIn(ReqIn),
    .ValIn(ValIn), .SoFIn(SoFIn), .EoFIn(EoFIn), .DataIn(DataIn),
    .ReqConfirm(ReqConfirm), .ValOut(ValOut), .SoFOut(SoFOut),
    .EoFOut(EoFOut), .ErrOut(ErrOut), .DataOut(DataOut),
    .Busy(Busy), .Owner(Owner)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_src();
    ValIn  = '0;
    SoFIn  = '0;
    EoFIn  = '0;
    DataIn = '0;
  endtask

  // Drives one byte on src and a bogus SoF/EoF byte on a non-owner source.
  task automatic drive_byte(input int src, input logic v, input logic s,
                            input logic e, input logic [7:0] d);
    int n;
    n = (src == 2) ? 3 : 2;
    clear_src();
    ValIn[src] = v;
    SoFIn[src] = s;
    EoFIn[src] = e;
    DataIn[8*src +: 8] = d;
    ValIn[n] = 1'b1;
    SoFIn[n] = 1'b1;
    EoFIn[n] = 1'b1;
    DataIn[8*n +: 8] = 8'h55;
  endtask

  task automatic send_frame(input int src, input int nbytes, input int sof_delay,
                            input logic with_eof);
    logic [7:0]  b;
    logic [11:0] exp;
    for (int d = 0; d < sof_delay; d++) begin
      drive_byte(src, 1'b1, 1'b0, 1'b0, 8'hEE);
      tick();
      chk("pre_sof_drop", {31'b0, ValOut}, 32'd0);
    end
    for (int i = 0; i < nbytes; i++) begin
      b = 8'(src * 64 + i);
      drive_byte(src, 1'b1, (i == 0), with_eof && (i == nbytes - 1), b);
      tick();
      exp = {1'b1, (i == 0), with_eof && (i == nbytes - 1), 1'b0, b};
      chk("fwd", {20'b0, ValOut, SoFOut, EoFOut, ErrOut, DataOut}, {20'b0, exp});
      if (i == 0) chk("conf_pulse", {28'b0, ReqConfirm}, 32'd0);
    end
    clear_src();
    $display("frame src=%0d bytes=%0d eof=%0d", src, nbytes, with_eof);
  endtask

  // Called one step after the EoF output cycle (e+1); ends at e+IFG+2.
  task automatic gap_then_grant(input logic [N-1:0] exp_conf, input int exp_owner);
    for (int j = 0; j < IFG - 1; j++) begin
      tick();
      chk("gap", {25'b0, ValOut, EoFOut, ReqConfirm, Busy}, {25'b0, 7'b0000001});
    end
    tick();
    chk("gap_idle", {27'b0, ReqConfirm, Busy}, 32'd0);
    tick();
    chk("regrant", {28'b0, ReqConfirm}, {28'b0, exp_conf});
    chk("owner", {30'b0, Owner}, exp_owner);
  endtask

  initial begin
    Rst    = 1'b1;
    LinkUp = 1'b1;
    ReqIn  = 4'b0011;
    clear_src();
    repeat (3) tick();
    chk("rst_conf", {28'b0, ReqConfirm}, 32'd0);
    chk("rst_out", {28'b0, ValOut, EoFOut, ErrOut, Busy}, 32'd0);
    chk("rst_owner", {30'b0, Owner}, 32'd0);

    // Simultaneous requests: source 0 wins.
    Rst = 1'b0;
    tick();
    chk("prio_conf", {28'b0, ReqConfirm}, 32'h1);
    chk("prio_busy", {31'b0, Busy}, 32'd1);
    send_frame(0, 64, 0, 1'b1);
    ReqIn = 4'b0010;
    gap_then_grant(4'b0010, 1);

    // Round robin 1 -> 2 -> 3 -> 1 with all three held.
    ReqIn = 4'b1110;
    send_frame(1, 60, 5, 1'b1);
    gap_then_grant(4'b0100, 2);
    send_frame(2, 4, 0, 1'b1);
    gap_then_grant(4'b1000, 3);
    send_frame(3, 4, 0, 1'b1);
    gap_then_grant(4'b0010, 1);

    // SoF timeout: nothing emitted, late SoF ignored, pointer still at 2.
    ReqIn = 4'b0000;
    for (int j = 0; j < STO - 1; j++) begin
      tick();
      chk("to_wait", {30'b0, Busy, ValOut}, 32'h2);
    end
    tick();
    chk("to_idle", {31'b0, Busy}, 32'd0);
    for (int j = 0; j < 5; j++) begin
      drive_byte(1, 1'b1, 1'b1, 1'b0, 8'hAA);
      tick();
      chk("late_sof", {30'b0, Busy, ValOut}, 32'd0);
    end
    clear_src();
    ReqIn = 4'b1110;
    tick();
    chk("to_rr", {28'b0, ReqConfirm}, 32'h4);

    // Link drop mid-frame: abort cycle, full gap, no grants while down.
    send_frame(2, 20, 0, 1'b0);
    LinkUp = 1'b0;
    drive_byte(2, 1'b1, 1'b0, 1'b0, 8'h77);
    tick();
    chk("abort", {20'b0, ValOut, SoFOut, EoFOut, ErrOut, DataOut}, {20'b0, 4'b0011, 8'h00});
    for (int j = 0; j < IFG - 1; j++) begin
      tick();
      chk("abort_gap", {29'b0, ValOut, ErrOut, Busy}, 32'h1);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("link_down", {27'b0, ReqConfirm, Busy}, 32'd0);
    end
    clear_src();
    LinkUp = 1'b1;
    tick();
    chk("link_up_grant", {28'b0, ReqConfirm}, 32'h8);

    // Reset in the middle of a frame.
    send_frame(3, 5, 0, 1'b0);
    Rst = 1'b1;
    drive_byte(3, 1'b1, 1'b0, 1'b0, 8'h99);
    tick();
    chk("rst_mid", {14'b0, ValOut, SoFOut, EoFOut, ErrOut, DataOut, ReqConfirm, Busy, Owner},
        32'd0);
    Rst = 1'b0;
    clear_src();
    tick();
    chk("rst_rr", {28'b0, ReqConfirm}, 32'h2);
    chk("rst_rr_owner", {30'b0, Owner}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
